// File: rtl/cm_cnt_nest.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cm_cnt_nest                                                  |
// | Description : Parametrised nested loop counter. C_LEVELS cascaded levels,  |
// |               level 0 innermost, each with its own inclusive upper bound.  |
// |               Provides per-level last flags, a one-cycle done pulse and    |
// |               either wrap-around or hold-at-end behaviour (C_WRAP).        |
// |               Optional macro CM_CNT_NEST_LATCH_UPPER_EN captures the       |
// |               bounds at run start instead of using them live.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cm_cnt_nest #(
  parameter int C_WIDTH  = 8,
  parameter int C_LEVELS = 3,
  parameter int C_WRAP   = 1
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_cnt_en,
  input  logic                        I_cnt_valid,
  input  logic [C_LEVELS*C_WIDTH-1:0] I_cnt_upper,
  output logic [C_LEVELS*C_WIDTH-1:0] O_cnt,
  output logic [C_LEVELS-1:0]         O_last,
  output logic                        O_done,
  output logic                        O_busy
);

  localparam int             C_TOTAL   = C_LEVELS * C_WIDTH;
  localparam logic [C_WIDTH-1:0] C_LVL_ONE = C_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [C_TOTAL-1:0] r_cnt;
  logic [C_TOTAL-1:0] w_cnt_nxt;
  logic [C_TOTAL-1:0] w_cnt_adv;
  logic [C_TOTAL-1:0] w_upper;
  logic [C_LEVELS:0]  w_carry;
  logic               w_final;
  logic               w_start;
  logic               r_done;
  logic               w_done_nxt;

  // A run starts on the edge that leaves IDLE with the enable high.
  assign w_start = (r_state == S_IDLE) && I_cnt_en;

`ifdef CM_CNT_NEST_LATCH_UPPER_EN
  logic [C_TOTAL-1:0] r_upper;

  // Capture the bounds once per run so live input changes cannot disturb it.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_upper <= '0;
    end else if (w_start) begin
      r_upper <= I_cnt_upper;
    end
  end

  assign w_upper = r_upper;
`else
  assign w_upper = I_cnt_upper;
`endif

  // Carry into level 0 is unconditional; each level passes it on only when
  // it sits exactly at its bound (equality, so an over-bound level never carries).
  assign w_carry[0] = 1'b1;

  generate
    for (genvar k = 0; k < C_LEVELS; k++) begin : g_lvl
      logic [C_WIDTH-1:0] w_lvl_cnt;
      logic [C_WIDTH-1:0] w_lvl_up;

      assign w_lvl_cnt    = r_cnt[k*C_WIDTH +: C_WIDTH];
      assign w_lvl_up     = w_upper[k*C_WIDTH +: C_WIDTH];
      assign O_last[k]    = (w_lvl_cnt == w_lvl_up);
      assign w_carry[k+1] = w_carry[k] & O_last[k];
      assign w_cnt_adv[k*C_WIDTH +: C_WIDTH] =
        !w_carry[k] ? w_lvl_cnt :
        (O_last[k]  ? '0 : w_lvl_cnt + C_LVL_ONE);
    end
  endgenerate

  // Carry out of the top level means every level is at its bound.
  assign w_final = w_carry[C_LEVELS];

  // State register.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, next count and done request; enable low always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (I_cnt_en) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!I_cnt_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (I_cnt_valid) begin
          // At the final count the advanced value is all-zero, which is the
          // wrap result; the hold variant keeps the final value instead.
          w_cnt_nxt = w_cnt_adv;
          if (w_final) begin
            w_done_nxt = 1'b1;
            if (C_WRAP == 0) begin
              w_state_nxt = S_HOLD;
              w_cnt_nxt   = r_cnt;
            end
          end
        end
      end
      S_HOLD: begin
        if (!I_cnt_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Count and done registers; done is a single-cycle pulse.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign O_cnt  = r_cnt;
  assign O_done = r_done;
  assign O_busy = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_cm_cnt_nest.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cm_cnt_nest                                               |
// | Description : Bench for cm_cnt_nest. Two instances: 8-bit wrapping and     |
// |               4-bit hold-at-end, compared every cycle against an odometer  |
// |               reference model under directed and random stimulus.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cm_cnt_nest;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [23:0] up0;
  logic [11:0] up1;
  logic [23:0] cnt0;
  logic [11:0] cnt1;
  logic [2:0]  last0;
  logic [2:0]  last1;
  logic        done0, done1, busy0, busy1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: per instance digit array, captured bounds, state, done.
  int md[2][3];
  int me[2][3];
  int mst[2];     // 0 idle, 1 run, 2 hold
  int mdone[2];

  always #5 clk = ~clk;

  cm_cnt_nest #(.C_WIDTH(8), .C_LEVELS(3), .C_WRAP(1)) u_dut0 (
    .I_clk(clk), .I_rst(rst), .I_cnt_en(en), .I_cnt_valid(valid),
    .I_cnt_upper(up0), .O_cnt(cnt0), .O_last(last0), .O_done(done0), .O_busy(busy0)
  );

  cm_cnt_nest #(.C_WIDTH(4), .C_LEVELS(3), .C_WRAP(0)) u_dut1 (
    .I_clk(clk), .I_rst(rst), .I_cnt_en(en), .I_cnt_valid(valid),
    .I_cnt_upper(up1), .O_cnt(cnt1), .O_last(last1), .O_done(done1), .O_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int id);
    return (id == 0) ? 8 : 4;
  endfunction

  function automatic int upin(input int id, input int k);
    if (id == 0) return int'(up0[k*8 +: 8]);
    return int'(up1[k*4 +: 4]);
  endfunction

  function automatic int eff(input int id, input int k);
`ifdef CM_CNT_NEST_LATCH_UPPER_EN
    return me[id][k];
`else
    return upin(id, k);
`endif
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      mst[id]   = 0;
      mdone[id] = 0;
      for (int k = 0; k < 3; k++) begin
        md[id][k] = 0;
        me[id][k] = 0;
      end
    end
  endtask

  // One clock edge of the reference, using the inputs present before the edge.
  task automatic model_step(input int id);
    int  m;
    bit  fin;
    m = 1 << wid(id);
    mdone[id] = 0;
    if (!en) begin
      mst[id] = 0;
      for (int k = 0; k < 3; k++) md[id][k] = 0;
    end else begin
      case (mst[id])
        0: begin
          mst[id] = 1;
          for (int k = 0; k < 3; k++) me[id][k] = upin(id, k);
        end
        1: if (valid) begin
          fin = 1'b1;
          for (int k = 0; k < 3; k++) if (md[id][k] != eff(id, k)) fin = 1'b0;
          if (fin) begin
            mdone[id] = 1;
            if (id == 0) begin
              for (int k = 0; k < 3; k++) md[id][k] = 0;
            end else begin
              mst[id] = 2;
            end
          end else begin
            for (int k = 0; k < 3; k++) begin
              if (md[id][k] == eff(id, k)) begin
                md[id][k] = 0;
              end else begin
                md[id][k] = (md[id][k] + 1) % m;
                break;
              end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int id);
    logic [31:0] v = '0;
    for (int k = 0; k < 3; k++) v |= 32'(md[id][k]) << (k * wid(id));
    return v;
  endfunction

  function automatic logic [31:0] exp_last(input int id);
    logic [31:0] v = '0;
    for (int k = 0; k < 3; k++) if (md[id][k] == eff(id, k)) v[k] = 1'b1;
    return v;
  endfunction

  task automatic check_all();
    chk("cnt0",  32'(cnt0),  exp_cnt(0));
    chk("last0", 32'(last0), exp_last(0));
    chk("done0", 32'(done0), 32'(mdone[0]));
    chk("busy0", 32'(busy0), 32'(mst[0] == 1));
    chk("cnt1",  32'(cnt1),  exp_cnt(1));
    chk("last1", 32'(last1), exp_last(1));
    chk("done1", 32'(done1), 32'(mdone[1]));
    chk("busy1", 32'(busy1), 32'(mst[1] == 1));
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_bounds(input int b0, input int b1, input int b2);
    up0 = {8'(b2), 8'(b1), 8'(b0)};
    up1 = {4'(b2), 4'(b1), 4'(b0)};
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    en    = 1'b0;
    valid = 1'b0;
    up0   = '0;
    up1   = '0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();

    // Bounds (2,1,3), valid every cycle: 24 counts then done.
    set_bounds(2, 1, 3);
    en    = 1'b1;
    valid = 1'b1;
    cycle();
    ndone = 0;
    repeat (24) begin
      cycle();
      ndone += int'(done0);
    end
    chk("done_once", 32'(ndone), 32'd1);
    chk("wrap_zero", 32'(cnt0), 32'd0);
    chk("hold_cnt",  32'(cnt1), 32'h312);
    chk("hold_busy", 32'(busy1), 32'd0);
    repeat (3) cycle();
    chk("hold_frozen", 32'(cnt1), 32'h312);
    en = 1'b0; valid = 1'b0;
    cycle();
    en = 1'b1;
    cycle();
    valid = 1'b1;
    repeat (2) cycle();
    chk("restart", 32'(cnt1), 32'h002);

    // Bounds all zero: every valid is the final count.
    en = 1'b0; valid = 1'b0;
    cycle();
    set_bounds(0, 0, 0);
    en = 1'b1;
    cycle();
    valid = 1'b1;
    repeat (4) begin
      cycle();
      chk("zero_last", 32'(last0), 32'd7);
      chk("zero_done", 32'(done0), 32'd1);
    end

    // Full range on the 4-bit instance: level 0 bound 15.
    en = 1'b0; valid = 1'b0;
    cycle();
    up0 = {8'd0, 8'd3, 8'd255};
    up1 = {4'd0, 4'd3, 4'd15};
    en = 1'b1;
    cycle();
    valid = 1'b1;
    repeat (16) cycle();
    chk("fullrange", 32'(cnt1), 32'h010);

    // Enable dropped together with the final valid: no done, count cleared.
    en = 1'b0; valid = 1'b0;
    cycle();
    set_bounds(1, 0, 0);
    en = 1'b1;
    cycle();
    valid = 1'b1;
    cycle();
    en = 1'b0;
    cycle();
    chk("endrop_done", 32'(done0), 32'd0);
    chk("endrop_cnt",  32'(cnt0),  32'd0);

    // Asynchronous reset in the middle of a run.
    set_bounds(2, 1, 3);
    en = 1'b1; valid = 1'b0;
    cycle();
    valid = 1'b1;
    repeat (5) cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cnt",  32'(cnt0),  32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    model_reset();
    check_all();
    en = 1'b0; valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Level 0 bound lowered from 3 to 1 while level 0 sits at 1.
    set_bounds(3, 2, 1);
    en = 1'b1;
    cycle();
    valid = 1'b1;
    cycle();
    up0[7:0] = 8'd1;
    up1[3:0] = 4'd1;
    cycle();
`ifdef CM_CNT_NEST_LATCH_UPPER_EN
    chk("bound_chg", 32'(cnt0), 32'h000002);
`else
    chk("bound_chg", 32'(cnt0), 32'h000100);
`endif
    repeat (6) cycle();

    // Random traffic with occasional bound changes, including mid-run.
    repeat (3000) begin
      en    = ($urandom_range(0, 19) != 0);
      valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        for (int k = 0; k < 3; k++) begin
          int v;
          v = ($urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 3));
          up0[k*8 +: 8] = 8'(v);
          up1[k*4 +: 4] = 4'(v);
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
